// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/flush controller.
// The pipeline is the master; the controller connects as slave.
interface hazard_flush_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdD;
    logic             RegWriteD;
    logic [1:0]       ResultSrcD;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic             PCSrcE;
    logic             DMemReqM;
    logic             DMemReadyM;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [CNT_W-1:0] StallCount;
    logic             MemTimeout;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, Rs1E, Rs2E,
               PCSrcE, DMemReqM, DMemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, StallCount, MemTimeout
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, Rs1E, Rs2E,
               PCSrcE, DMemReqM, DMemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, StallCount, MemTimeout
    );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Hazard and flush controller for the 5-stage RV32I pipeline: forwarding selects,
// load-use stalls, branch flushes, data-memory wait freeze, stall counter, timeout flag.
module hazard_flush_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input logic                clk,
    input logic                reset,
    hazard_flush_ctrl_if.slave hz
);
    typedef enum logic [0:0] {RUN, MEM_WAIT} state_e;

    localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [4:0]       rd_e_q, rd_e_d, rd_m_q, rd_m_d, rd_w_q, rd_w_d;
    logic             reg_write_e_q, reg_write_e_d;
    logic             reg_write_m_q, reg_write_m_d;
    logic             reg_write_w_q, reg_write_w_d;
    logic [1:0]       result_src_e_q, result_src_e_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic       mem_stall, lw_stall;
    logic       stall_fetch, stall_decode, stall_exec, stall_mem;
    logic       flush_decode, flush_exec, flush_wb;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m, input logic we_m,
        input logic [4:0] rd_w, input logic we_w
    );
        if (we_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
        if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    // The wait is seen combinationally: a fresh request without ready stalls at once,
    // and an outstanding one keeps stalling until ready arrives.
    assign mem_stall = !hz.DMemReadyM && (state_q == MEM_WAIT || hz.DMemReqM);

    // Only the E result source is shadowed; load-use is the sole consumer of it.
    assign lw_stall = (result_src_e_q == 2'b01) && reg_write_e_q && (rd_e_q != 5'd0) &&
                      ((rd_e_q == hz.Rs1D) || (rd_e_q == hz.Rs2D));

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path infers a latch.
        stall_fetch  = 1'b0;
        stall_decode = 1'b0;
        stall_exec   = 1'b0;
        stall_mem    = 1'b0;
        flush_decode = 1'b0;
        flush_exec   = 1'b0;
        flush_wb     = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        if (!reset) begin
            if (mem_stall) begin
                stall_fetch  = 1'b1;
                stall_decode = 1'b1;
                stall_exec   = 1'b1;
                stall_mem    = 1'b1;
                flush_wb     = 1'b1;
            end else if (hz.PCSrcE) begin
                flush_decode = 1'b1;
                flush_exec   = 1'b1;
            end else if (lw_stall) begin
                stall_fetch  = 1'b1;
                stall_decode = 1'b1;
                flush_exec   = 1'b1;
            end
            fwd_a = fwd_sel(hz.Rs1E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
            fwd_b = fwd_sel(hz.Rs2E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (hz.DMemReqM && !hz.DMemReadyM) state_d = MEM_WAIT;
            MEM_WAIT: if (hz.DMemReadyM) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        rd_e_d         = rd_e_q;
        rd_m_d         = rd_m_q;
        rd_w_d         = rd_w_q;
        reg_write_e_d  = reg_write_e_q;
        reg_write_m_d  = reg_write_m_q;
        reg_write_w_d  = reg_write_w_q;
        result_src_e_d = result_src_e_q;
        if (mem_stall) begin
            rd_w_d        = 5'd0;
            reg_write_w_d = 1'b0;
        end else begin
            rd_w_d         = rd_m_q;
            reg_write_w_d  = reg_write_m_q;
            rd_m_d         = rd_e_q;
            reg_write_m_d  = reg_write_e_q;
            rd_e_d         = flush_exec ? 5'd0 : hz.RdD;
            reg_write_e_d  = flush_exec ? 1'b0 : hz.RegWriteD;
            result_src_e_d = flush_exec ? 2'b00 : hz.ResultSrcD;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_fetch && stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);

        tmo_cnt_d = 16'd0;
        if (mem_stall) tmo_cnt_d = (tmo_cnt_q == TMO_LIMIT) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
        mem_timeout_d = mem_timeout_q || (tmo_cnt_d == TMO_LIMIT);
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            rd_e_q         <= 5'd0;
            rd_m_q         <= 5'd0;
            rd_w_q         <= 5'd0;
            reg_write_e_q  <= 1'b0;
            reg_write_m_q  <= 1'b0;
            reg_write_w_q  <= 1'b0;
            result_src_e_q <= 2'b00;
            stall_count_q  <= '0;
            tmo_cnt_q      <= 16'd0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_e_q         <= rd_e_d;
            rd_m_q         <= rd_m_d;
            rd_w_q         <= rd_w_d;
            reg_write_e_q  <= reg_write_e_d;
            reg_write_m_q  <= reg_write_m_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_e_q <= result_src_e_d;
            stall_count_q  <= stall_count_d;
            tmo_cnt_q      <= tmo_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign hz.StallF     = stall_fetch;
    assign hz.StallD     = stall_decode;
    assign hz.StallE     = stall_exec;
    assign hz.StallM     = stall_mem;
    assign hz.FlushD     = flush_decode;
    assign hz.FlushE     = flush_exec;
    assign hz.FlushW     = flush_wb;
    assign hz.ForwardAE  = fwd_a;
    assign hz.ForwardBE  = fwd_b;
    assign hz.StallCount = stall_count_q;
    assign hz.MemTimeout = mem_timeout_q;
endmodule
